// File: rtl/gemm_pkg.sv
// Shared definitions for the streaming output-stationary GEMM tile.
// Holds the tile FSM encoding, the default operand/accumulator typedefs
// and a small helper used to size the drain phase.
package gemm_pkg;

  localparam int GEMM_DATA_W = 8;
  localparam int GEMM_ACC_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } gemm_state_t;

  typedef logic signed [GEMM_DATA_W-1:0] gemm_operand_t;
  typedef logic signed [GEMM_ACC_W-1:0]  gemm_acc_t;

  // Last drain-counter value: the skew plus forwarding path to the far PE
  // spans rows+cols-1 registers, so the drain counter runs 0..rows+cols-1.
  function automatic int gemm_drain_last(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/gemm_os_pe.sv
// Output-stationary processing element: one signed MAC per valid beat,
// forwards A rightwards and B downwards with their valid bits.
// Optional feature macro: GEMM_STREAM_SAT_EN (saturating accumulate);
// without it the accumulator wraps modulo 2^ACC_W.
module gemm_os_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic                     a_vld_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic                     b_vld_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic                     a_vld_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic                     b_vld_out,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_next;
  logic                       mac_en;

  assign mac_en   = a_vld_in & b_vld_in;
  assign prod     = a_in * b_in;
  // Size cast of a signed value sign-extends the product into the accumulator width.
  assign prod_ext = ACC_W'(prod);

`ifdef GEMM_STREAM_SAT_EN
  // Add with one guard bit; clamp to the signed range when the guard disagrees.
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] x,
                                                       input logic signed [ACC_W-1:0] y);
    logic [ACC_W:0] s;
    s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) begin
        sat_add = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sat_add = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction
`endif

  // Next accumulator value: saturating or wrapping sum.
  always_comb begin
    acc_next = acc;
`ifdef GEMM_STREAM_SAT_EN
    acc_next = sat_add(acc, prod_ext);
`else
    acc_next = acc + prod_ext;
`endif
  end

  // Operand forwarding registers and the stationary accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_out     <= '0;
      b_out     <= '0;
      a_vld_out <= 1'b0;
      b_vld_out <= 1'b0;
      acc       <= '0;
    end else if (clr) begin
      a_out     <= '0;
      b_out     <= '0;
      a_vld_out <= 1'b0;
      b_vld_out <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      b_out     <= b_in;
      a_vld_out <= a_vld_in;
      b_vld_out <= b_vld_in;
      if (mac_en) begin
        acc <= acc_next;
      end
    end
  end

endmodule

// File: rtl/gemm_stream_tile.sv
// Streaming ROWS x COLS output-stationary GEMM tile. Accepts k_len beats of
// (A column-slice, B row-slice), skews them into the PE grid and presents
// the C tile with a valid/ready handshake.
// Optional feature macro: GEMM_STREAM_SAT_EN (saturating accumulators, in gemm_os_pe).
module gemm_stream_tile
  import gemm_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int MAX_K  = 256
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [$clog2(MAX_K+1)-1:0]          k_len,
  input  logic [ROWS-1:0][DATA_W-1:0]         a_data,
  input  logic [COLS-1:0][DATA_W-1:0]         b_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] res_data,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic                                busy
);

  localparam int KW         = $clog2(MAX_K+1);
  localparam int DRAIN_LAST = gemm_drain_last(ROWS, COLS);
  localparam int CW         = $clog2(DRAIN_LAST+1);

  gemm_state_t     state;
  logic [KW-1:0]   beat_cnt;
  logic [KW-1:0]   k_len_r;
  logic [CW-1:0]   drain_cnt;
  logic            accept;
  logic            tile_go;

  // in_ready is a registered copy of (state == STREAM), so it qualifies acceptance.
  assign accept  = in_ready & in_valid;
  assign tile_go = (state == IDLE) & start;

  // Tile control FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      k_len_r   <= '0;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k_len_r   <= k_len;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            busy      <= 1'b1;
            if (k_len == '0) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state    <= STREAM;
              in_ready <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt == k_len_r - KW'(1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == CW'(DRAIN_LAST)) begin
            state     <= DONE;
            res_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  logic signed [DATA_W-1:0] a_fwd [ROWS][COLS+1];
  logic                     a_vld [ROWS][COLS+1];
  logic signed [DATA_W-1:0] b_fwd [ROWS+1][COLS];
  logic                     b_vld [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  acc   [ROWS][COLS];

  // A lane r: capture stage plus r skew registers, so row r enters the grid r cycles late.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic signed [DATA_W-1:0] sk   [r+1];
    logic                     sk_v [r+1];

    // Shift the A slice and its beat-valid bit through the lane delay line.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i <= r; i++) begin
          sk[i]   <= '0;
          sk_v[i] <= 1'b0;
        end
      end else begin
        sk[0]   <= a_data[r];
        sk_v[0] <= accept;
        for (int i = 1; i <= r; i++) begin
          sk[i]   <= sk[i-1];
          sk_v[i] <= sk_v[i-1];
        end
      end
    end

    assign a_fwd[r][0] = sk[r];
    assign a_vld[r][0] = sk_v[r];
  end

  // B lane c: capture stage plus c skew registers.
  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic signed [DATA_W-1:0] sk   [c+1];
    logic                     sk_v [c+1];

    // Shift the B slice and its beat-valid bit through the lane delay line.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i <= c; i++) begin
          sk[i]   <= '0;
          sk_v[i] <= 1'b0;
        end
      end else begin
        sk[0]   <= b_data[c];
        sk_v[0] <= accept;
        for (int i = 1; i <= c; i++) begin
          sk[i]   <= sk[i-1];
          sk_v[i] <= sk_v[i-1];
        end
      end
    end

    assign b_fwd[0][c] = sk[c];
    assign b_vld[0][c] = sk_v[c];
  end

  // PE grid: PE(r,c) sees a beat r+c+1 edges after it was accepted.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      gemm_os_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk       (clk),
        .reset     (reset),
        .clr       (tile_go),
        .a_in      (a_fwd[r][c]),
        .a_vld_in  (a_vld[r][c]),
        .b_in      (b_fwd[r][c]),
        .b_vld_in  (b_vld[r][c]),
        .a_out     (a_fwd[r][c+1]),
        .a_vld_out (a_vld[r][c+1]),
        .b_out     (b_fwd[r+1][c]),
        .b_vld_out (b_vld[r+1][c]),
        .acc       (acc[r][c])
      );
      assign res_data[r][c] = acc[r][c];
    end
  end

  // Operands leaving the grid edges have no consumer; fold them together explicitly.
  logic [ROWS-1:0] a_edge_unused;
  logic [COLS-1:0] b_edge_unused;
  for (genvar r = 0; r < ROWS; r++) begin : g_a_edge
    assign a_edge_unused[r] = ^{a_fwd[r][COLS], a_vld[r][COLS]};
  end
  for (genvar c = 0; c < COLS; c++) begin : g_b_edge
    assign b_edge_unused[c] = ^{b_fwd[ROWS][c], b_vld[ROWS][c]};
  end

endmodule
